// File: rtl/ifu_mem_req_sched.sv
`timescale 1ns/1ps
// ifu_mem_req_sched: arbitrates the IFU memory read port between demand line
// fills and next-line prefetches. One transaction in flight, demand first,
// demand merges into an in-flight prefetch of the same line, and repeated
// prefetches of the most recently filled prefetch line are suppressed.
//
// Handshakes: a request moves when valid and ready are both high at a rising
// Clock edge. Neither side may make valid depend on the other side's ready.
// mem_reqValidOut/mem_reqTagOut stay stable until mem_reqReadyIn is seen.
module ifu_mem_req_sched #(
  parameter int TAG_WIDTH = 28,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Rst,
  input  logic                 dmd_reqValidIn,
  input  logic [TAG_WIDTH-1:0] dmd_reqTagIn,
  output logic                 dmd_reqReadyOut,
  input  logic                 pf_reqValidIn,
  input  logic [TAG_WIDTH-1:0] pf_reqTagIn,
  output logic                 mem_reqValidOut,
  output logic [TAG_WIDTH-1:0] mem_reqTagOut,
  input  logic                 mem_reqReadyIn,
  input  logic                 mem_rspValidIn,
  input  logic [TAG_WIDTH-1:0] mem_rspTagIn,
  output logic                 rsp_fillValidOut,
  output logic                 rsp_isPrefetchOut,
  output logic                 busyOut,
  output logic [CNT_WIDTH-1:0] pf_issueCntOut,
  output logic [1:0]           dbg_stateOut
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [TAG_WIDTH-1:0]   cur_tag_q, cur_tag_d;
  logic                   cur_is_pf_q, cur_is_pf_d;
  logic                   pend_v_q, pend_v_d;
  logic [TAG_WIDTH-1:0]   pend_tag_q, pend_tag_d;
  logic                   lastpf_v_q, lastpf_v_d;
  logic [TAG_WIDTH-1:0]   lastpf_tag_q, lastpf_tag_d;
  logic                   mem_req_valid_q, mem_req_valid_d;
  logic [TAG_WIDTH-1:0]   mem_req_tag_q, mem_req_tag_d;
  logic                   fill_valid_q, fill_valid_d;
  logic                   fill_is_pf_q, fill_is_pf_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  logic dmd_ready;
  logic dmd_acc;
  logic pf_dup;
  logic rsp_match;

  // Next-state and next-output computation for the scheduler.
  always_comb begin
    state_d       = state_q;
    cur_tag_d     = cur_tag_q;
    cur_is_pf_d   = cur_is_pf_q;
    pend_v_d      = pend_v_q;
    pend_tag_d    = pend_tag_q;
    lastpf_v_d    = lastpf_v_q;
    lastpf_tag_d  = lastpf_tag_q;
    cnt_d         = cnt_q;
    fill_valid_d  = 1'b0;
    fill_is_pf_d  = 1'b0;

    // Outside IDLE a demand is only taken while a prefetch occupies the port
    // and the single pending slot is free.
    dmd_ready = (state_q == S_IDLE) || (cur_is_pf_q && !pend_v_q);
    dmd_acc   = dmd_reqValidIn && dmd_ready;
    pf_dup    = lastpf_v_q && (pf_reqTagIn == lastpf_tag_q);
    rsp_match = (state_q == S_WAIT) && mem_rspValidIn && (mem_rspTagIn == cur_tag_q);

    case (state_q)
      S_IDLE: begin
        if (dmd_reqValidIn) begin
          cur_tag_d   = dmd_reqTagIn;
          cur_is_pf_d = 1'b0;
          state_d     = S_REQ;
        end else if (pf_reqValidIn && !pf_dup) begin
          cur_tag_d   = pf_reqTagIn;
          cur_is_pf_d = 1'b1;
          state_d     = S_REQ;
          if (cnt_q != {CNT_WIDTH{1'b1}}) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          end
        end
      end
      S_REQ, S_WAIT: begin
        if (rsp_match) begin
          fill_valid_d = 1'b1;
          fill_is_pf_d = cur_is_pf_q;
          if (cur_is_pf_q) begin
            lastpf_v_d   = 1'b1;
            lastpf_tag_d = cur_tag_q;
          end
          // A queued demand (or one arriving right now) reissues with no
          // IDLE bubble.
          if (pend_v_q) begin
            cur_tag_d   = pend_tag_q;
            cur_is_pf_d = 1'b0;
            pend_v_d    = 1'b0;
            state_d     = S_REQ;
          end else if (dmd_acc) begin
            cur_tag_d   = dmd_reqTagIn;
            cur_is_pf_d = 1'b0;
            state_d     = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          if ((state_q == S_REQ) && mem_reqReadyIn) begin
            state_d = S_WAIT;
          end
          if (dmd_acc) begin
            if (dmd_reqTagIn == cur_tag_q) begin
              cur_is_pf_d = 1'b0;
            end else begin
              pend_v_d   = 1'b1;
              pend_tag_d = dmd_reqTagIn;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    mem_req_valid_d = (state_d == S_REQ);
    mem_req_tag_d   = cur_tag_d;
  end

  // State and registered outputs; reset abandons any transaction.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_q         <= S_IDLE;
      cur_tag_q       <= '0;
      cur_is_pf_q     <= 1'b0;
      pend_v_q        <= 1'b0;
      pend_tag_q      <= '0;
      lastpf_v_q      <= 1'b0;
      lastpf_tag_q    <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_tag_q   <= '0;
      fill_valid_q    <= 1'b0;
      fill_is_pf_q    <= 1'b0;
      cnt_q           <= '0;
    end else begin
      state_q         <= state_d;
      cur_tag_q       <= cur_tag_d;
      cur_is_pf_q     <= cur_is_pf_d;
      pend_v_q        <= pend_v_d;
      pend_tag_q      <= pend_tag_d;
      lastpf_v_q      <= lastpf_v_d;
      lastpf_tag_q    <= lastpf_tag_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_tag_q   <= mem_req_tag_d;
      fill_valid_q    <= fill_valid_d;
      fill_is_pf_q    <= fill_is_pf_d;
      cnt_q           <= cnt_d;
    end
  end

  // Ready is held low while reset is asserted so every output reads 0.
  assign dmd_reqReadyOut   = Rst && dmd_ready;
  assign mem_reqValidOut   = mem_req_valid_q;
  assign mem_reqTagOut     = mem_req_tag_q;
  assign rsp_fillValidOut  = fill_valid_q;
  assign rsp_isPrefetchOut = fill_is_pf_q;
  assign busyOut           = (state_q != S_IDLE) || pend_v_q;
  assign pf_issueCntOut    = cnt_q;
  assign dbg_stateOut      = state_q;

endmodule

// File: tb/tb_ifu_mem_req_sched.sv
`timescale 1ns/1ps
// Bench for ifu_mem_req_sched: directed scenarios, memory-side handshakes and
// fill pulses checked against expected queues by a negedge monitor.
module tb_ifu_mem_req_sched;

  localparam int TW = 28;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic          dmd_valid = 1'b0;
  logic [TW-1:0] dmd_tag = '0;
  logic          dmd_ready;
  logic          pf_valid = 1'b0;
  logic [TW-1:0] pf_tag = '0;
  logic          mem_valid;
  logic [TW-1:0] mem_tag;
  logic          mem_ready = 1'b0;
  logic          rsp_valid = 1'b0;
  logic [TW-1:0] rsp_tag = '0;
  logic          fill_valid;
  logic          fill_is_pf;
  logic          busy;
  logic [15:0]   pf_cnt;
  logic [1:0]    dbg_state;

  ifu_mem_req_sched #(.TAG_WIDTH(TW), .CNT_WIDTH(16)) dut (
    .Clock(clk), .Rst(rst_n),
    .dmd_reqValidIn(dmd_valid), .dmd_reqTagIn(dmd_tag), .dmd_reqReadyOut(dmd_ready),
    .pf_reqValidIn(pf_valid), .pf_reqTagIn(pf_tag),
    .mem_reqValidOut(mem_valid), .mem_reqTagOut(mem_tag), .mem_reqReadyIn(mem_ready),
    .mem_rspValidIn(rsp_valid), .mem_rspTagIn(rsp_tag),
    .rsp_fillValidOut(fill_valid), .rsp_isPrefetchOut(fill_is_pf),
    .busyOut(busy), .pf_issueCntOut(pf_cnt), .dbg_stateOut(dbg_state)
  );

  // ---------------- saturation DUT (2-bit counter) ----------------
  logic          s_dmd_ready;
  logic          s_pf_valid = 1'b0;
  logic [TW-1:0] s_pf_tag = '0;
  logic          s_mem_valid;
  logic [TW-1:0] s_mem_tag;
  logic          s_rsp_valid = 1'b0;
  logic [TW-1:0] s_rsp_tag = '0;
  logic          s_fill_valid;
  logic          s_fill_is_pf;
  logic          s_busy;
  logic [1:0]    s_cnt;
  logic [1:0]    s_dbg_state;

  ifu_mem_req_sched #(.TAG_WIDTH(TW), .CNT_WIDTH(2)) dut_sat (
    .Clock(clk), .Rst(rst_n),
    .dmd_reqValidIn(1'b0), .dmd_reqTagIn('0), .dmd_reqReadyOut(s_dmd_ready),
    .pf_reqValidIn(s_pf_valid), .pf_reqTagIn(s_pf_tag),
    .mem_reqValidOut(s_mem_valid), .mem_reqTagOut(s_mem_tag), .mem_reqReadyIn(1'b1),
    .mem_rspValidIn(s_rsp_valid), .mem_rspTagIn(s_rsp_tag),
    .rsp_fillValidOut(s_fill_valid), .rsp_isPrefetchOut(s_fill_is_pf),
    .busyOut(s_busy), .pf_issueCntOut(s_cnt), .dbg_stateOut(s_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [TW-1:0] exp_q[$];       // expected memory request tags, in order
  logic          exp_fill_q[$];  // expected isPrefetch of each fill, in order

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT completes a memory request
  // handshake or emits a fill pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_valid && mem_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL mem_req: unexpected request tag 0x%0h, none expected", mem_tag);
        end else begin
          logic [TW-1:0] e;
          e = exp_q.pop_front();
          if (mem_tag !== e) begin
            fails++;
            $display("FAIL mem_req: got tag 0x%0h expected 0x%0h", mem_tag, e);
          end
        end
      end
      if (fill_valid) begin
        tests++;
        if (exp_fill_q.size() == 0) begin
          fails++;
          $display("FAIL fill: unexpected fill isPrefetch=%0b, none expected", fill_is_pf);
        end else begin
          logic e;
          e = exp_fill_q.pop_front();
          if (fill_is_pf !== e) begin
            fails++;
            $display("FAIL fill: got isPrefetch=%0b expected %0b", fill_is_pf, e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept the pending request after rdy_dly cycles, answer rsp_dly cycles
  // later; returns in the cycle where the fill pulse should be visible.
  task automatic serve(input logic [TW-1:0] tag, input int rdy_dly, input int rsp_dly);
    repeat (rdy_dly) tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    repeat (rsp_dly) tick();
    rsp_valid = 1'b1;
    rsp_tag   = tag;
    tick();
    rsp_valid = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset then idle
    #2;
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_mem_tag", {4'd0, mem_tag}, 32'd0);
    chk("rst_ready", {31'd0, dmd_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fill", {31'd0, fill_valid}, 32'd0);
    chk("rst_cnt", {16'd0, pf_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_ready", {31'd0, dmd_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    rsp_valid = 1'b1;
    rsp_tag   = 28'h5;
    tick();
    rsp_valid = 1'b0;
    chk("stray_rsp_fill", {31'd0, fill_valid}, 32'd0);
    chk("stray_rsp_busy", {31'd0, busy}, 32'd0);
    tick();

    // Demand only
    dmd_valid = 1'b1;
    dmd_tag   = 28'h100;
    exp_q.push_back(28'h100);
    exp_fill_q.push_back(1'b0);
    tick();
    dmd_valid = 1'b0;
    chk("dmd_req_valid", {31'd0, mem_valid}, 32'd1);
    chk("dmd_req_tag", {4'd0, mem_tag}, 32'h100);
    chk("dmd_busy", {31'd0, busy}, 32'd1);
    chk("dmd_inflight_ready", {31'd0, dmd_ready}, 32'd0);
    tick();
    chk("dmd_req_hold_valid", {31'd0, mem_valid}, 32'd1);
    chk("dmd_req_hold_tag", {4'd0, mem_tag}, 32'h100);
    serve(28'h100, 0, 5);
    chk("dmd_fill", {31'd0, fill_valid}, 32'd1);
    chk("dmd_fill_pf", {31'd0, fill_is_pf}, 32'd0);
    chk("dmd_done_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("dmd_fill_pulse", {31'd0, fill_valid}, 32'd0);

    // Priority and dedupe
    dmd_valid = 1'b1;
    dmd_tag   = 28'h100;
    pf_valid  = 1'b1;
    pf_tag    = 28'h101;
    exp_q.push_back(28'h100);
    exp_fill_q.push_back(1'b0);
    tick();
    dmd_valid = 1'b0;
    chk("prio_tag", {4'd0, mem_tag}, 32'h100);
    chk("prio_cnt", {16'd0, pf_cnt}, 32'd0);
    serve(28'h100, 0, 2);
    exp_q.push_back(28'h101);
    exp_fill_q.push_back(1'b1);
    tick();
    chk("pf_issue_valid", {31'd0, mem_valid}, 32'd1);
    chk("pf_issue_tag", {4'd0, mem_tag}, 32'h101);
    chk("pf_issue_cnt", {16'd0, pf_cnt}, 32'd1);
    serve(28'h101, 1, 1);
    chk("pf_fill_pf", {31'd0, fill_is_pf}, 32'd1);
    repeat (3) tick();
    chk("dedupe_valid", {31'd0, mem_valid}, 32'd0);
    chk("dedupe_busy", {31'd0, busy}, 32'd0);
    chk("dedupe_cnt", {16'd0, pf_cnt}, 32'd1);
    pf_valid = 1'b0;
    tick();

    // Merge demand into in-flight prefetch
    pf_valid = 1'b1;
    pf_tag   = 28'h200;
    exp_q.push_back(28'h200);
    tick();
    pf_valid = 1'b0;
    chk("merge_cnt", {16'd0, pf_cnt}, 32'd2);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    dmd_valid = 1'b1;
    dmd_tag   = 28'h200;
    chk("merge_ready", {31'd0, dmd_ready}, 32'd1);
    tick();
    dmd_valid = 1'b0;
    chk("merge_no_req", {31'd0, mem_valid}, 32'd0);
    chk("merge_busy", {31'd0, busy}, 32'd1);
    exp_fill_q.push_back(1'b0);
    rsp_valid = 1'b1;
    rsp_tag   = 28'h200;
    tick();
    rsp_valid = 1'b0;
    chk("merge_fill", {31'd0, fill_valid}, 32'd1);
    chk("merge_fill_pf", {31'd0, fill_is_pf}, 32'd0);
    // lastpf must not hold 0x200: the same prefetch issues again
    pf_valid = 1'b1;
    pf_tag   = 28'h200;
    exp_q.push_back(28'h200);
    exp_fill_q.push_back(1'b1);
    tick();
    pf_valid = 1'b0;
    chk("merge_lastpf_reissue", {31'd0, mem_valid}, 32'd1);
    chk("merge_lastpf_cnt", {16'd0, pf_cnt}, 32'd3);
    serve(28'h200, 0, 1);
    tick();

    // Pending demand behind a prefetch
    pf_valid = 1'b1;
    pf_tag   = 28'h300;
    exp_q.push_back(28'h300);
    tick();
    pf_valid = 1'b0;
    chk("pend_cnt", {16'd0, pf_cnt}, 32'd4);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    dmd_valid = 1'b1;
    dmd_tag   = 28'h400;
    chk("pend_first_ready", {31'd0, dmd_ready}, 32'd1);
    tick();
    dmd_tag = 28'h500;
    chk("pend_second_ready", {31'd0, dmd_ready}, 32'd0);
    tick();
    dmd_valid = 1'b0;
    rsp_valid = 1'b1;
    rsp_tag   = 28'h999;
    tick();
    rsp_valid = 1'b0;
    chk("wrong_tag_fill", {31'd0, fill_valid}, 32'd0);
    chk("wrong_tag_busy", {31'd0, busy}, 32'd1);
    exp_fill_q.push_back(1'b1);
    exp_q.push_back(28'h400);
    rsp_valid = 1'b1;
    rsp_tag   = 28'h300;
    tick();
    rsp_valid = 1'b0;
    chk("pend_fill", {31'd0, fill_valid}, 32'd1);
    chk("pend_fill_pf", {31'd0, fill_is_pf}, 32'd1);
    chk("pend_no_bubble_valid", {31'd0, mem_valid}, 32'd1);
    chk("pend_no_bubble_tag", {4'd0, mem_tag}, 32'h400);
    exp_fill_q.push_back(1'b0);
    serve(28'h400, 0, 1);
    tick();
    chk("pend_done_busy", {31'd0, busy}, 32'd0);

    // Reset during WAIT
    dmd_valid = 1'b1;
    dmd_tag   = 28'h600;
    exp_q.push_back(28'h600);
    tick();
    dmd_valid = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_valid", {31'd0, mem_valid}, 32'd0);
    chk("mid_rst_tag", {4'd0, mem_tag}, 32'd0);
    chk("mid_rst_cnt", {16'd0, pf_cnt}, 32'd0);
    chk("mid_rst_ready", {31'd0, dmd_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    rsp_valid = 1'b1;
    rsp_tag   = 28'h600;
    tick();
    rsp_valid = 1'b0;
    chk("late_rsp_fill", {31'd0, fill_valid}, 32'd0);
    tick();
    chk("late_rsp_busy", {31'd0, busy}, 32'd0);

    // Saturating counter, 2-bit instance
    for (int i = 0; i < 5; i++) begin
      s_pf_valid = 1'b1;
      s_pf_tag   = 28'h10 + 28'(i);
      tick();
      s_pf_valid = 1'b0;
      tick();
      s_rsp_valid = 1'b1;
      s_rsp_tag   = 28'h10 + 28'(i);
      tick();
      s_rsp_valid = 1'b0;
      chk("sat_fill", {31'd0, s_fill_valid}, 32'd1);
      chk("sat_cnt", {30'd0, s_cnt}, (i < 3) ? 32'(i + 1) : 32'd3);
    end
    tick();

    chk("exp_req_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("exp_fill_queue_empty", 32'(exp_fill_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
